// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner.
// The optional toggle outputs are enabled with INPUT_CONDITIONER_TOGGLE_EN.
package input_conditioner_pkg;

    localparam int SYNC_STAGES_DEFAULT     = 2;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Debounce counter width; a 1-cycle filter still gets a 1-bit counter.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioned input: synchronizer chain, optional debounce, registered edge pulses.
// INPUT_CONDITIONER_TOGGLE_EN adds a latched toggle output.
module conditioner_channel
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit DEBOUNCE_EN     = 1'b1,
    parameter bit RESET_VAL       = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
`ifdef INPUT_CONDITIONER_TOGGLE_EN
    ,
    output logic toggle_o
`endif
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], async_i};
        stable_d = stable_q;
        cnt_d    = '0;
        if (!DEBOUNCE_EN) begin
            stable_d = sync;
        end else if (sync != stable_q) begin
            // Accept on the DEBOUNCE_CYCLES-th consecutive mismatch; any match clears the count.
            if (cnt_q == CNT_MAX) stable_d = sync;
            else                  cnt_d    = cnt_q + 1'b1;
        end
        rise_d = stable_d & ~stable_q;
        fall_d = ~stable_d & stable_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q   <= {SYNC_STAGES{RESET_VAL}};
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef INPUT_CONDITIONER_TOGGLE_EN
    logic toggle_q, toggle_d;

    // Flips in the same cycle the rise pulse appears.
    always_comb toggle_d = toggle_q ^ rise_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) toggle_q <= 1'b0;
        else         toggle_q <= toggle_d;
    end

    assign toggle_o = toggle_q;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel pad input conditioner: sync, per-channel debounce, edge pulses.
// INPUT_CONDITIONER_TOGGLE_EN adds toggle_o (one latched bit per channel).
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int                  CHANNELS        = 6,
    parameter int                  SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int                  DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [CHANNELS-1:0] DEBOUNCE_MASK   = {CHANNELS{1'b1}},
    parameter logic [CHANNELS-1:0] RESET_LEVEL     = {CHANNELS{1'b0}}
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [CHANNELS-1:0] async_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o
`ifdef INPUT_CONDITIONER_TOGGLE_EN
    ,
    output logic [CHANNELS-1:0] toggle_o
`endif
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        conditioner_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DEBOUNCE_EN    (DEBOUNCE_MASK[g]),
            .RESET_VAL      (RESET_LEVEL[g])
        ) u_ch (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .async_i (async_i[g]),
            .level_o (level_o[g]),
            .rise_o  (rise_o[g]),
            .fall_o  (fall_o[g])
`ifdef INPUT_CONDITIONER_TOGGLE_EN
            ,
            .toggle_o(toggle_o[g])
`endif
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: each stimulus cycle queues its expected
// outputs; a monitor pops one entry per clock edge and compares.
module tb_input_conditioner;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [5:0] async_i;
    logic [5:0] level_o, rise_o, fall_o;
`ifdef INPUT_CONDITIONER_TOGGLE_EN
    logic [5:0] toggle_o;
    logic [5:0] tog_exp = '0;
`endif

    typedef struct {
        logic [5:0] lvl;
        logic [5:0] r;
        logic [5:0] f;
`ifdef INPUT_CONDITIONER_TOGGLE_EN
        logic [5:0] tog;
`endif
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc_n  = 0;

    input_conditioner #(
        .CHANNELS       (6),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .DEBOUNCE_MASK  (6'b111101),
        .RESET_LEVEL    (6'b000010)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (async_i),
        .level_o (level_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o)
`ifdef INPUT_CONDITIONER_TOGGLE_EN
        ,
        .toggle_o(toggle_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc_n, act, req);
        end
    endtask

    // Monitor: one expected entry per rising edge, sampled 1 time unit later.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            cyc_n++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("level", level_o, e.lvl);
                chk("rise", rise_o, e.r);
                chk("fall", fall_o, e.f);
                chk("rise_and_fall", rise_o & fall_o, 6'b000000);
`ifdef INPUT_CONDITIONER_TOGGLE_EN
                chk("toggle", toggle_o, e.tog);
`endif
            end
        end
    end

    // One clock: drive inputs, queue the outputs expected after the next edge.
    task automatic cyc(input logic rst, input logic [5:0] a, input logic [5:0] lvl,
                       input logic [5:0] r, input logic [5:0] f);
        exp_t x;
        reset_i = rst;
        async_i = a;
        x.lvl = lvl;
        x.r   = r;
        x.f   = f;
`ifdef INPUT_CONDITIONER_TOGGLE_EN
        tog_exp = rst ? 6'b000000 : (tog_exp ^ r);
        x.tog   = tog_exp;
`endif
        exp_q.push_back(x);
        @(negedge clk_i);
    endtask

    task automatic hold(input logic rst, input logic [5:0] a, input logic [5:0] lvl, input int n);
        for (int i = 0; i < n; i++) cyc(rst, a, lvl, 6'b000000, 6'b000000);
    endtask

    initial begin
        // Reset, then idle with the reset pattern on the pads.
        hold(1'b1, 6'b000010, 6'b000010, 3);
        hold(1'b0, 6'b000010, 6'b000010, 10);

        // ch0 debounced rise lands on edge 6, then the matching fall.
        hold(1'b0, 6'b000011, 6'b000010, 5);
        cyc (1'b0, 6'b000011, 6'b000011, 6'b000001, 6'b000000);
        hold(1'b0, 6'b000011, 6'b000011, 2);
        hold(1'b0, 6'b000010, 6'b000011, 5);
        cyc (1'b0, 6'b000010, 6'b000010, 6'b000000, 6'b000001);
        hold(1'b0, 6'b000010, 6'b000010, 2);

        // ch0 3-cycle glitch rejected.
        hold(1'b0, 6'b000011, 6'b000010, 3);
        hold(1'b0, 6'b000010, 6'b000010, 7);

        // ch0 4-cycle pulse accepted; fall follows the release.
        hold(1'b0, 6'b000011, 6'b000010, 4);
        hold(1'b0, 6'b000010, 6'b000010, 1);
        cyc (1'b0, 6'b000010, 6'b000011, 6'b000001, 6'b000000);
        hold(1'b0, 6'b000010, 6'b000011, 3);
        cyc (1'b0, 6'b000010, 6'b000010, 6'b000000, 6'b000001);
        hold(1'b0, 6'b000010, 6'b000010, 2);

        // ch1 pass-through: fall on edge 3, then a 1-cycle glitch as rise+fall.
        hold(1'b0, 6'b000000, 6'b000010, 2);
        cyc (1'b0, 6'b000000, 6'b000000, 6'b000000, 6'b000010);
        hold(1'b0, 6'b000000, 6'b000000, 2);
        cyc (1'b0, 6'b000010, 6'b000000, 6'b000000, 6'b000000);
        hold(1'b0, 6'b000000, 6'b000000, 1);
        cyc (1'b0, 6'b000000, 6'b000010, 6'b000010, 6'b000000);
        cyc (1'b0, 6'b000000, 6'b000000, 6'b000000, 6'b000010);
        hold(1'b0, 6'b000000, 6'b000000, 2);

        // All channels up together, then down together.
        hold(1'b0, 6'b111111, 6'b000000, 2);
        cyc (1'b0, 6'b111111, 6'b000010, 6'b000010, 6'b000000);
        hold(1'b0, 6'b111111, 6'b000010, 2);
        cyc (1'b0, 6'b111111, 6'b111111, 6'b111101, 6'b000000);
        hold(1'b0, 6'b111111, 6'b111111, 2);
        hold(1'b0, 6'b000000, 6'b111111, 2);
        cyc (1'b0, 6'b000000, 6'b111101, 6'b000000, 6'b000010);
        hold(1'b0, 6'b000000, 6'b111101, 2);
        cyc (1'b0, 6'b000000, 6'b000000, 6'b000000, 6'b111101);
        hold(1'b0, 6'b000000, 6'b000000, 2);

        // Mixed pattern.
        hold(1'b0, 6'b101010, 6'b000000, 2);
        cyc (1'b0, 6'b101010, 6'b000010, 6'b000010, 6'b000000);
        hold(1'b0, 6'b101010, 6'b000010, 2);
        cyc (1'b0, 6'b101010, 6'b101010, 6'b101000, 6'b000000);
        hold(1'b0, 6'b101010, 6'b101010, 2);

        // Reset while ch2 count is 2: no pulses, filter restarts from scratch.
        hold(1'b0, 6'b101110, 6'b101010, 4);
        cyc (1'b1, 6'b101110, 6'b000010, 6'b000000, 6'b000000);
        hold(1'b0, 6'b101110, 6'b000010, 5);
        cyc (1'b0, 6'b101110, 6'b101110, 6'b101100, 6'b000000);
        hold(1'b0, 6'b101110, 6'b101110, 2);

        // Second accepted rise on ch2.
        hold(1'b0, 6'b101010, 6'b101110, 5);
        cyc (1'b0, 6'b101010, 6'b101010, 6'b000000, 6'b000100);
        hold(1'b0, 6'b101010, 6'b101010, 2);
        hold(1'b0, 6'b101110, 6'b101010, 5);
        cyc (1'b0, 6'b101110, 6'b101110, 6'b000100, 6'b000000);
        hold(1'b0, 6'b101110, 6'b101110, 2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
